// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: opcode, class and encoder result types shared with the control path
package instr_encoder_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  typedef enum logic [1:0] {
    CLS_R      = 2'b00,
    CLS_LOAD   = 2'b01,
    CLS_STORE  = 2'b10,
    CLS_BRANCH = 2'b11
  } cls_e;
  typedef struct packed {
    logic [31:0] word;
    logic        bad;
  } enc_t;
endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: field-source handshake and imem write port of the encoder
interface instr_encoder_if #(parameter int ADDR_W = 8);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_cls;
  logic [2:0]        in_funct3;
  logic              in_funct7b5;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [12:0]       in_imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic [ADDR_W:0]   wr_count;
  logic              err;
  modport master (
    output in_valid, in_cls, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, in_imm, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata, wr_count, err
  );
  modport slave (
    input  in_valid, in_cls, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, in_imm, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata, wr_count, err
  );
endinterface

// File: rtl/instr_encoder_sync_fifo.sv
// sync_fifo: power-of-two FIFO with wrap-bit pointers and clear taking priority over push/pop
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] ram [DEPTH];
  always_comb begin
    wr_d = clr ? '0 : wr_q + (AW+1)'(push);
    rd_d = clr ? '0 : rd_q + (AW+1)'(pop);
  end
  assign empty = wr_q == rd_q;
  assign full  = wr_q == {~rd_q[AW], rd_q[AW-1:0]};
  assign head  = ram[rd_q[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  always_ff @(posedge clk)
    if (push && !clr) ram[wr_q[AW-1:0]] <= din;
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: encodes RV32I R/lw/sw/beq fields and streams the words into imem through a FIFO
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 4,
  parameter int BASE_ADDR = 0
) (
  input logic           clk,
  input logic           rst,
  input logic           clr,
  instr_encoder_if.slave bus
);
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
  function automatic enc_t encode(
    input logic [1:0]  cls,
    input logic [2:0]  f3,
    input logic        f7b5,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [12:0] imm
  );
    enc_t e;
    e.word = cls == CLS_R     ? {1'b0, f7b5, 5'b0, rs2, rs1, f3, rd, OP_R} :
             cls == CLS_LOAD  ? {imm[11:0], rs1, f3, rd, OP_LOAD} :
             cls == CLS_STORE ? {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE} :
                                {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
    e.bad  = cls == CLS_R      ? 1'b0 :
             cls == CLS_BRANCH ? imm[0] : imm[12] != imm[11];
    return e;
  endfunction
  enc_t              enc;
  logic              accept, push, pop, full, empty;
  logic [31:0]       head;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   (enc.word),
    .full  (full),
    .empty (empty),
    .head  (head)
  );
  always_comb begin
    enc    = encode(bus.in_cls, bus.in_funct3, bus.in_funct7b5, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm);
    accept = bus.in_valid && bus.in_ready;
    push   = accept && !enc.bad;
    pop    = !empty && bus.mem_ready;
    addr_d = clr ? BASE : pop ? addr_q + 1'b1 : addr_q;
    cnt_d  = clr ? '0 : (pop && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
    err_d  = clr ? 1'b0 : err_q || (accept && enc.bad);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr_q <= BASE;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  assign bus.in_ready  = !full && !clr;
  assign bus.mem_we    = !empty;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = empty ? '0 : head;
  assign bus.wr_count  = cnt_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: vector table plus scoreboard of expected imem writes for instr_encoder
module tb_instr_encoder;
  typedef struct {
    logic [1:0]  cls;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [12:0] imm;
    logic [31:0] word;
    logic        bad;
  } vec_t;
  typedef struct {
    logic [7:0]  addr;
    logic [31:0] word;
  } sb_t;
  logic clk = 0, rst = 1, clr = 0;
  int   checks = 0, errors = 0;
  sb_t  sbq[$];
  logic [7:0] exp_addr = 0;
  logic       exp_err = 0;
  vec_t vecs[11];
  instr_encoder_if #(.ADDR_W(8)) b1();
  instr_encoder_if #(.ADDR_W(2)) b2();
  instr_encoder #(.ADDR_W(8), .DEPTH(4), .BASE_ADDR(0)) dut (.clk(clk), .rst(rst), .clr(clr), .bus(b1));
  instr_encoder #(.ADDR_W(2), .DEPTH(4), .BASE_ADDR(0)) dut2 (.clk(clk), .rst(rst), .clr(clr), .bus(b2));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask
  always @(negedge clk)
    if (!rst && !clr && b1.mem_we && b1.mem_ready) begin
      sb_t e;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h want no write", b1.mem_addr, b1.mem_wdata);
      end else begin
        e = sbq.pop_front();
        chk("wr_addr", 32'(b1.mem_addr), 32'(e.addr));
        chk("wr_data", b1.mem_wdata, e.word);
      end
    end
  task automatic send(input vec_t v);
    int n = 0;
    while (!b1.in_ready && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!b1.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready 0 want 1");
      return;
    end
    b1.in_valid = 1;
    b1.in_cls = v.cls;
    b1.in_funct3 = v.f3;
    b1.in_funct7b5 = v.f7;
    b1.in_rd = v.rd;
    b1.in_rs1 = v.rs1;
    b1.in_rs2 = v.rs2;
    b1.in_imm = v.imm;
    if (v.bad) exp_err = 1;
    else begin
      sbq.push_back('{exp_addr, v.word});
      exp_addr++;
    end
    @(posedge clk);
    #1;
    b1.in_valid = 0;
  endtask
  task automatic do_clr();
    clr = 1;
    sbq.delete();
    exp_addr = 0;
    exp_err = 0;
    #1;
    chk("in_ready_during_clr", 32'(b1.in_ready), 0);
    @(posedge clk);
    #1;
    clr = 0;
  endtask
  task automatic drain();
    for (int i = 0; i < 64; i++) begin
      if (sbq.size() == 0) break;
      @(posedge clk);
    end
    #1;
    chk("drain", sbq.size(), 0);
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    vecs[0]  = '{2'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 13'h0000, 32'h002081B3, 1'b0};
    vecs[1]  = '{2'd0, 3'd0, 1'b1, 5'd5, 5'd6, 5'd7, 13'h0000, 32'h407302B3, 1'b0};
    vecs[2]  = '{2'd1, 3'd2, 1'b0, 5'd5, 5'd0, 5'd0, 13'h0008, 32'h00802283, 1'b0};
    vecs[3]  = '{2'd2, 3'd2, 1'b0, 5'd0, 5'd0, 5'd5, 13'h000C, 32'h00502623, 1'b0};
    vecs[4]  = '{2'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 13'h1FF8, 32'hFE208CE3, 1'b0};
    vecs[5]  = '{2'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 13'h0003, 32'h00000000, 1'b1};
    vecs[6]  = '{2'd1, 3'd2, 1'b0, 5'd1, 5'd2, 5'd0, 13'h0800, 32'h00000000, 1'b1};
    vecs[7]  = '{2'd1, 3'd2, 1'b0, 5'd1, 5'd2, 5'd0, 13'h1FFC, 32'hFFC12083, 1'b0};
    vecs[8]  = '{2'd3, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 13'h0010, 32'h00000863, 1'b0};
    vecs[9]  = '{2'd2, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 13'h1000, 32'h00000000, 1'b1};
    vecs[10] = '{2'd3, 3'd1, 1'b0, 5'd0, 5'd1, 5'd2, 13'h0004, 32'h00209263, 1'b0};
    {b1.in_valid, b1.in_cls, b1.in_funct3, b1.in_funct7b5, b1.in_rd, b1.in_rs1, b1.in_rs2, b1.in_imm} = '0;
    {b2.in_valid, b2.in_cls, b2.in_funct3, b2.in_funct7b5, b2.in_rd, b2.in_rs1, b2.in_rs2, b2.in_imm} = '0;
    b1.mem_ready = 1;
    b2.mem_ready = 1;
    tick(2);
    chk("rst_in_ready", 32'(b1.in_ready), 1);
    chk("rst_mem_we", 32'(b1.mem_we), 0);
    chk("rst_mem_addr", 32'(b1.mem_addr), 0);
    chk("rst_mem_wdata", b1.mem_wdata, 0);
    chk("rst_wr_count", 32'(b1.wr_count), 0);
    chk("rst_err", 32'(b1.err), 0);
    rst = 0;
    tick(1);
    send(vecs[0]);
    chk("lat_mem_we", 32'(b1.mem_we), 1);
    chk("lat_mem_wdata", b1.mem_wdata, 32'h002081B3);
    chk("lat_mem_addr", 32'(b1.mem_addr), 0);
    drain();
    chk("add_wr_count", 32'(b1.wr_count), 1);
    chk("add_mem_addr", 32'(b1.mem_addr), 1);
    chk("add_idle_we", 32'(b1.mem_we), 0);
    do_clr();
    for (int i = 0; i < 11; i++) send(vecs[i]);
    drain();
    chk("tbl_wr_count", 32'(b1.wr_count), 8);
    chk("tbl_mem_addr", 32'(b1.mem_addr), 32'(exp_addr));
    chk("tbl_err", 32'(b1.err), 32'(exp_err));
    do_clr();
    chk("err_cleared", 32'(b1.err), 0);
    send(vecs[5]);
    chk("bad_err", 32'(b1.err), 1);
    chk("bad_no_write", 32'(b1.mem_we), 0);
    tick(3);
    chk("err_sticky", 32'(b1.err), 1);
    do_clr();
    chk("err_after_clr", 32'(b1.err), 0);
    b1.mem_ready = 0;
    for (int i = 0; i < 4; i++) send(vecs[i]);
    chk("full_in_ready", 32'(b1.in_ready), 0);
    chk("stall_we", 32'(b1.mem_we), 1);
    chk("stall_head0", b1.mem_wdata, vecs[0].word);
    tick(3);
    chk("stall_head_hold", b1.mem_wdata, vecs[0].word);
    chk("stall_addr_hold", 32'(b1.mem_addr), 0);
    b1.mem_ready = 1;
    drain();
    chk("stall_wr_count", 32'(b1.wr_count), 4);
    chk("stall_mem_addr", 32'(b1.mem_addr), 4);
    b1.mem_ready = 0;
    send(vecs[7]);
    send(vecs[8]);
    chk("pre_clr_we", 32'(b1.mem_we), 1);
    do_clr();
    chk("clr_mem_we", 32'(b1.mem_we), 0);
    chk("clr_mem_addr", 32'(b1.mem_addr), 0);
    chk("clr_wr_count", 32'(b1.wr_count), 0);
    b1.mem_ready = 1;
    send(vecs[2]);
    drain();
    send(vecs[9]);
    b1.mem_ready = 0;
    send(vecs[3]);
    send(vecs[4]);
    chk("pre_rst_err", 32'(b1.err), 1);
    chk("pre_rst_count", 32'(b1.wr_count), 1);
    #2 rst = 1;
    #1;
    chk("arst_in_ready", 32'(b1.in_ready), 1);
    chk("arst_mem_we", 32'(b1.mem_we), 0);
    chk("arst_mem_addr", 32'(b1.mem_addr), 0);
    chk("arst_mem_wdata", b1.mem_wdata, 0);
    chk("arst_wr_count", 32'(b1.wr_count), 0);
    chk("arst_err", 32'(b1.err), 0);
    sbq.delete();
    exp_addr = 0;
    exp_err = 0;
    tick(1);
    rst = 0;
    b1.mem_ready = 1;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      b2.in_valid = 1;
      b2.in_cls = vecs[i].cls;
      b2.in_funct3 = vecs[i].f3;
      b2.in_funct7b5 = vecs[i].f7;
      b2.in_rd = vecs[i].rd;
      b2.in_rs1 = vecs[i].rs1;
      b2.in_rs2 = vecs[i].rs2;
      b2.in_imm = vecs[i].imm;
      tick(1);
      b2.in_valid = 0;
      chk($sformatf("w2_we_%0d", i), 32'(b2.mem_we), 1);
      chk($sformatf("w2_addr_%0d", i), 32'(b2.mem_addr), i % 4);
      chk($sformatf("w2_data_%0d", i), b2.mem_wdata, vecs[i].word);
      tick(1);
    end
    chk("w2_wr_count_sat", 32'(b2.wr_count), 4);
    chk("w2_addr_wrap", 32'(b2.mem_addr), 1);
    chk("end_no_pending", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Encodes RV32I instruction fields for the four classes the core's control path executes (R-type, lw, sw, beq) into 32-bit machine words.
- Buffers the encoded words in a small FIFO and writes them sequentially into instruction memory.
- Lets a test harness or boot loader fill imem for the single-cycle core without precompiled hex files.
- Sits between a field source (valid/ready handshake) and the imem write port.

Parameters:
- ADDR_W, 8, imem word-address width; write address wraps modulo 2^ADDR_W.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- BASE_ADDR, 0, word address loaded on reset and on clr.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- clr  input  1  synchronous clear: flush FIFO, reload address, clear err.
- in_valid  input  1  field source has an instruction.
- in_ready  output  1  encoder can accept.
- in_cls  input  2  class: 00 R-type, 01 load, 10 store, 11 branch.
- in_funct3  input  3  funct3 field.
- in_funct7b5  input  1  funct7 bit 5; R-type only, other bits of funct7 are 0.
- in_rd  input  5  destination register.
- in_rs1  input  5  source register 1.
- in_rs2  input  5  source register 2.
- in_imm  input  13  signed immediate (byte offset for branch).
- mem_we  output  1  write request to imem.
- mem_addr  output  ADDR_W  imem word address.
- mem_wdata  output  32  encoded instruction.
- mem_ready  input  1  imem accepts the write this cycle.
- wr_count  output  ADDR_W+1  words written since reset/clr, saturating.
- err  output  1  sticky: an instruction was rejected.

Behaviour:
- Reset values: in_ready=1, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, wr_count=0, err=0; FIFO empty.
- Accept occurs on in_valid & in_ready. in_ready = !full && !clr. There is no same-cycle pass-through when full.
- Encoding is combinational on accept; the word is pushed into the FIFO at that clock edge. It appears on mem_wdata the next cycle if the FIFO was empty (1-cycle latency).
- Encodings:
  - R-type: {0,f7b5,00000, rs2, rs1, f3, rd, 0110011}.
  - load: {imm[11:0], rs1, f3, rd, 0000011}.
  - store: {imm[11:5], rs2, rs1, f3, imm[4:0], 0100011}.
  - branch: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 1100011}.
- Range check:
  - load/store: rejected if imm[12] != imm[11].
  - branch: rejected if imm[0]=1.
  - A rejected instruction is still accepted (handshake completes) but is not pushed; err is set and stays set until rst or clr.
- Output side:
  - mem_we = FIFO non-empty; mem_wdata = FIFO head. Both are held stable while mem_we & !mem_ready.
  - On mem_we & mem_ready: pop, mem_addr += 1 (wraps 2^ADDR_W-1 -> 0), wr_count += 1 saturating at 2^ADDR_W.
- Simultaneous push and pop: occupancy unchanged; legal at any non-full level, including empty→head-valid ordering (a push into an empty FIFO is visible next cycle).
- clr has priority over push and pop in the same cycle: FIFO emptied, mem_addr=BASE_ADDR, wr_count=0, err=0; the in-flight word is discarded.
- Asynchronous rst mid-transfer: all state goes to reset values immediately; a pending imem write is abandoned.
- No state machine beyond the FIFO pointers and the address/count registers.

Decomposition:
- Shared package holds:
  - opcode constants OP_R=0110011, OP_LOAD=0000011, OP_STORE=0100011, OP_BRANCH=1100011; these are the same constants the control decoder uses.
  - class codes CLS_R/CLS_LOAD/CLS_STORE/CLS_BRANCH.
- One sub-module: sync_fifo (parameters WIDTH=32, DEPTH; push/pop/full/empty/head).
- Encoding and range check stay in instr_encoder as a combinational function.

Test Plan:
- add x3,x1,x2 (cls 00, f3 0, f7b5 0) with mem_ready=1 -> one write, mem_addr=0, mem_wdata=0x002081B3, wr_count=1.
- lw x5,8(x0) then sw x5,12(x0) back-to-back -> writes 0x00802283 @0 then 0x00502623 @1, one per cycle.
- beq x1,x2,-8 (imm 0x1FF8) -> 0xFE208CE3. Then beq with imm=3 -> no write, err=1; err persists until clr.
- Hold mem_ready=0 and push 4 words -> in_ready=0 after the 4th; mem_wdata stays on word 0. Release mem_ready -> 4 writes in order at addresses 0..3.
- ADDR_W=2, write 5 words -> addresses 0,1,2,3,0. wr_count saturates at 4.
- Assert clr while the FIFO holds 2 words -> next cycle mem_we=0, mem_addr=BASE_ADDR, wr_count=0. Assert rst mid-stall -> all outputs at reset values asynchronously.
